// File: rtl/subtractor_8bit_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module  : subtractor_8bit_serial_pkg
// Brief   : FSM state encoding and bit-counter sizing for the serial subtractor.
// Revision: 1.0
// ============================================================================
package subtractor_8bit_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int C_DEFAULT_WIDTH = 8;
    localparam int C_CNT_W         = $clog2(C_DEFAULT_WIDTH + 1);

    // Counter width for an arbitrary operand width; must be able to hold WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/subtractor_8bit_serial_full_subtractor.sv
`default_nettype none
// ============================================================================
// Module  : full_subtractor
// Brief   : One-bit combinational full subtractor (difference and borrow-out).
// Revision: 1.0
// ============================================================================
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule
`default_nettype wire

// File: rtl/subtractor_8bit_serial.sv
`default_nettype none
// ============================================================================
// Module  : subtractor_8bit_serial
// Brief   : Bit-serial (LSB first) a - b - bin with valid/ready handshakes.
//           Define SUB_OVERFLOW_EN to add the registered signed-overflow port.
// Revision: 1.0
// ============================================================================
module subtractor_8bit_serial
    import subtractor_8bit_serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SUB_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_br;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;
    logic               w_d;
    logic               w_br_next;
    logic               w_last;

    full_subtractor u_fs (
        .x    (r_a[0]),
        .y    (r_b[0]),
        .bin  (r_br),
        .d    (w_d),
        .bout (w_br_next)
    );

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next_state = BUSY;
            end
            BUSY: begin
                if (w_last) w_next_state = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Operands shift right so the active bit is always at index 0; result
    // bits enter at the MSB and end up LSB-aligned after WIDTH shifts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_br   <= 1'b0;
            r_cnt  <= '0;
            r_diff <= '0;
            r_bout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_br  <= bin;
                        r_cnt <= '0;
                    end
                end
                BUSY: begin
                    r_a    <= r_a >> 1;
                    r_b    <= r_b >> 1;
                    r_br   <= w_br_next;
                    r_diff <= {w_d, r_diff[WIDTH-1:1]};
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (w_last) r_bout <= w_br_next;
                end
                default: ;
            endcase
        end
    end

    assign diff = r_diff;
    assign bout = r_bout;

`ifdef SUB_OVERFLOW_EN
    logic r_ovf;

    // On the last BUSY cycle the stage sees the operand MSBs and yields diff MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (r_state == BUSY && w_last) begin
            r_ovf <= (r_a[0] != r_b[0]) && (w_d != r_a[0]);
        end
    end

    assign ovf = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_subtractor_8bit_serial.sv
`default_nettype none
// ============================================================================
// Module  : tb_subtractor_8bit_serial
// Brief   : Directed-table and random self-checking bench for the serial subtractor.
// Revision: 1.0
// ============================================================================
module tb_subtractor_8bit_serial;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SUB_OVERFLOW_EN
    logic         ovf;
`endif

    subtractor_8bit_serial #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
`ifdef SUB_OVERFLOW_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bo;
        logic       ov;
    } vec_t;

    vec_t vecs [9];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called #1 after an edge; returns #1 after the accepting edge.
    task automatic accept(input logic [7:0] va, input logic [7:0] vb, input logic vbin);
        bit ok;
        ok = 0;
        for (int k = 0; k < 40; k++) begin
            if (in_ready) begin
                ok = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) check("in_ready_timeout", 0, 1);
        a        = va;
        b        = vb;
        bin      = vbin;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = ~va;
        b        = ~vb;
        bin      = ~vbin;
    endtask

    // Counts edges after the accepting edge until out_valid is seen.
    task automatic wait_out(output int edges, output bit ok);
        edges = 0;
        ok    = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            edges++;
            if (out_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("out_valid_timeout", 0, 1);
    endtask

    task automatic check_result(input string tag, input vec_t v);
        check({tag, "_diff"}, 32'(diff), 32'(v.d));
        check({tag, "_bout"}, 32'(bout), 32'(v.bo));
`ifdef SUB_OVERFLOW_EN
        check({tag, "_ovf"}, 32'(ovf), 32'(v.ov));
`endif
    endtask

    initial begin
        int   edges;
        bit   ok;
        int   seen;
        int   last_acc;
        vec_t v;
        logic [8:0] full;

        vecs[0] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[1] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[2] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{8'h33, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0};
        vecs[5] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[6] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[7] = '{8'h01, 8'h01, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[8] = '{8'hC8, 8'h64, 1'b0, 8'h64, 1'b0, 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_diff", 32'(diff), 0);
        check("rst_bout", 32'(bout), 0);
        rst = 1'b0;

        // Directed table, out_ready held high before DONE.
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            accept(vecs[i].a, vecs[i].b, vecs[i].bin);
            wait_out(edges, ok);
            // Accepting edge plus W BUSY edges: out_valid after edge W+1 counted inclusively.
            check($sformatf("latency_%0d", i), 32'(edges + 1), 32'(W + 1));
            check_result($sformatf("vec%0d", i), vecs[i]);
            @(posedge clk);
            #1;
            check($sformatf("one_pulse_%0d", i), 32'(out_valid), 0);
        end

        // Result held in DONE while consumer stalls; new operands ignored.
        out_ready = 1'b0;
        accept(8'h5A, 8'h5A, 1'b0);
        wait_out(edges, ok);
        a        = 8'hFF;
        b        = 8'h00;
        bin      = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("hold_out_valid", 32'(out_valid), 1);
            check("hold_in_ready", 32'(in_ready), 0);
            check("hold_diff", 32'(diff), 32'h00);
            check("hold_bout", 32'(bout), 0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("drain_out_valid", 32'(out_valid), 0);
        check("drain_in_ready", 32'(in_ready), 1);
        check("drain_no_accept", 32'(dut.r_state), 32'(0));

        // Reset during the 4th BUSY cycle discards the operation.
        accept(8'h33, 8'h11, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_in_ready", 32'(in_ready), 1);
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_diff", 32'(diff), 0);
        check("midrst_bout", 32'(bout), 0);
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            if (out_valid) seen++;
            @(posedge clk);
            #1;
        end
        check("midrst_no_pulse", 32'(seen), 0);
        accept(8'h33, 8'h11, 1'b0);
        wait_out(edges, ok);
        check_result("after_rst", vecs[4]);
        @(posedge clk);
        #1;

        // Back-to-back random stream with out_ready tied high.
        in_valid = 1'b1;
        last_acc = 0;
        for (int i = 0; i < 1000; i++) begin
            v.a   = 8'($urandom);
            v.b   = 8'($urandom);
            v.bin = 1'($urandom);
            full  = {1'b0, v.a} - {1'b0, v.b} - {8'b0, v.bin};
            v.d   = full[7:0];
            v.bo  = full[8];
            v.ov  = (v.a[7] != v.b[7]) && (v.d[7] != v.a[7]);
            a     = v.a;
            b     = v.b;
            bin   = v.bin;
            ok    = 0;
            for (int k = 0; k < 40; k++) begin
                if (in_ready) begin
                    ok = 1;
                    break;
                end
                @(posedge clk);
                #1;
            end
            if (!ok) check("rand_ready_timeout", 0, 1);
            @(posedge clk);
            #1;
            if (i > 0) check("rand_period", 32'(cyc - last_acc), 32'(W + 2));
            last_acc = cyc;
            a   = ~v.a;
            b   = ~v.b;
            wait_out(edges, ok);
            check_result("rand", v);
        end
        in_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
